// File: rtl/core_stream_host.sv
// Host-side partner of the CORE frame interface: buffers one upstream frame, replays it
// to CORE as one gap-free in_valid burst, then forwards CORE's reply burst downstream.
module core_stream_host #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_last,
  output logic              in_valid,
  output logic [DATA_W-1:0] in_data,
  input  logic              out_valid,
  input  logic [DATA_W-1:0] out_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic [CNT_W-1:0]  rx_cnt,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_ovf
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_GAP, S_WAIT_RX, S_RECV, S_DONE
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [CNT_W-1:0]   len, idx;
  logic [TW-1:0]      timer;
  logic               accept, frame_full;
  logic [CNT_W-1:0]   wr_ptr, len_nxt;

  assign accept     = src_valid & src_ready;
  assign wr_ptr     = (state == S_IDLE) ? '0 : len;
  assign len_nxt    = wr_ptr + 1'b1;
  assign frame_full = (len_nxt == CNT_W'(DEPTH));

  // Frame buffer carries no reset; len qualifies its contents.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= src_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      len         <= '0;
      idx         <= '0;
      timer       <= '0;
      src_ready   <= 1'b0;
      in_valid    <= 1'b0;
      in_data     <= '0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      rx_cnt      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      done     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      in_valid <= 1'b0;
      in_data  <= '0;
      case (state)
        S_IDLE, S_LOAD: begin
          if (accept) begin
            len  <= len_nxt;
            busy <= 1'b1;
            if (state == S_IDLE) begin
              err_ovf     <= 1'b0;
              err_timeout <= 1'b0;
              rx_cnt      <= '0;
            end
            if (src_last || frame_full) begin
              // A full buffer without src_last closes the frame; the rest waits.
              if (!src_last) err_ovf <= 1'b1;
              src_ready <= 1'b0;
              idx       <= '0;
              state     <= S_SEND;
            end else begin
              src_ready <= 1'b1;
              state     <= S_LOAD;
            end
          end else if (state == S_IDLE) begin
            src_ready <= 1'b1;
          end
        end
        S_SEND: begin
          if (idx == len) begin
            state <= S_GAP;
          end else begin
            in_valid <= 1'b1;
            in_data  <= mem[idx[AW-1:0]];
            idx      <= idx + 1'b1;
          end
        end
        S_GAP: begin
          timer <= '0;
          state <= S_WAIT_RX;
        end
        S_WAIT_RX: begin
          if (out_valid) begin
            rx_valid <= 1'b1;
            rx_data  <= out_data;
            rx_cnt   <= rx_cnt + 1'b1;
            state    <= S_RECV;
          end else if (timer == TMAX) begin
            err_timeout <= 1'b1;
            done        <= 1'b1;
            state       <= S_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RECV: begin
          if (out_valid) begin
            rx_valid <= 1'b1;
            rx_data  <= out_data;
            if (rx_cnt != {CNT_W{1'b1}}) rx_cnt <= rx_cnt + 1'b1;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy      <= 1'b0;
          src_ready <= 1'b1;
          len       <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
